// File: rtl/mon_tx_arbiter.sv
// mon_tx_arbiter: schedules 40-bit packets from four requesters to the
// monitor-link Sender, in the mon_clk domain.
//  - req[0] (power-on) has absolute priority; req[1..3] (kbd, mouse, mic)
//    share round-robin, starting at rr_ptr.
//  - With sample_req_mode=1 a launch waits for a sample_req_tick slot.
//  - A presented packet waits at most TIMEOUT cycles for out_retrieved, then
//    it is dropped. Either way the owner gets a one-cycle ack.
//  - GAP_CYCLES idle cycles separate two launches.
// Ports:
//  mon_clk, mon_reset        clock, synchronous active-high reset
//  req[3:0], req_data0..3    pending levels and their packet words
//  ack[3:0]                  packet consumed or dropped
//  sample_req_mode/_tick     audio slot alignment controls
//  out_data, out_valid       packet presented to the Sender
//  out_retrieved             Sender took out_data
//  drop                      timeout pulse
//  busy                      FSM not in IDLE
//  drop_count[7:0]           saturating drop counter (MON_TX_DROP_COUNT_EN only)
// Build option: define MON_TX_DROP_COUNT_EN to add the drop_count port.
module mon_tx_arbiter #(
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 4096,
  parameter int unsigned TW         = 13
) (
  input  logic        mon_clk,
  input  logic        mon_reset,
  input  logic [3:0]  req,
  input  logic [39:0] req_data0,
  input  logic [39:0] req_data1,
  input  logic [39:0] req_data2,
  input  logic [39:0] req_data3,
  output logic [3:0]  ack,
  input  logic        sample_req_mode,
  input  logic        sample_req_tick,
  output logic [39:0] out_data,
  output logic        out_valid,
  input  logic        out_retrieved,
  output logic        drop,
  output logic        busy
`ifdef MON_TX_DROP_COUNT_EN
  ,
  output logic [7:0]  drop_count
`endif
);

  localparam int unsigned GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SLOT = 2'd1,
    PRESENT   = 2'd2,
    GAP       = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    rr_ptr_q, rr_ptr_d;
  logic [1:0]    grant_q, grant_d;
  logic [39:0]   out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          drop_q, drop_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [GW-1:0] gap_q, gap_d;

  logic [1:0]    rr_c1, rr_c2, rr_after;
  logic [1:0]    win_idx;
  logic          win_found;
  logic [39:0]   win_data;

  // Round-robin successor over 1..3.
  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return (p == 2'd3) ? 2'd1 : p + 2'd1;
  endfunction

  assign rr_c1    = rr_next(rr_ptr_q);
  assign rr_c2    = rr_next(rr_c1);
  // Pointer after the current grant completes; power-on grants leave it alone.
  assign rr_after = (grant_q == 2'd0) ? rr_ptr_q : rr_next(grant_q);

  // Winner selection: power-on first, then rr_ptr, rr_ptr+1, rr_ptr+2.
  always_comb begin
    win_idx   = 2'd0;
    win_found = 1'b1;
    if (req[0])             win_idx = 2'd0;
    else if (req[rr_ptr_q]) win_idx = rr_ptr_q;
    else if (req[rr_c1])    win_idx = rr_c1;
    else if (req[rr_c2])    win_idx = rr_c2;
    else                    win_found = 1'b0;
  end

  // Packet word of the winner.
  always_comb begin
    win_data = req_data0;
    unique case (win_idx)
      2'd1:    win_data = req_data1;
      2'd2:    win_data = req_data2;
      2'd3:    win_data = req_data3;
      default: win_data = req_data0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    drop_d      = 1'b0;
    tmo_d       = tmo_q;
    gap_d       = gap_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d    = win_idx;
          out_data_d = win_data;
          state_d    = WAIT_SLOT;
        end
      end
      WAIT_SLOT: begin
        if (!sample_req_mode || sample_req_tick) begin
          out_valid_d = 1'b1;
          tmo_d       = '0;
          state_d     = PRESENT;
        end
      end
      PRESENT: begin
        // Retrieve takes precedence over a timeout in the same cycle.
        if (out_retrieved || (tmo_q == TW'(TIMEOUT - 1))) begin
          drop_d      = !out_retrieved;
          out_valid_d = 1'b0;
          rr_ptr_d    = rr_after;
          tmo_d       = '0;
          gap_d       = '0;
          state_d     = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_LAST)) state_d = IDLE;
        else                        gap_d   = gap_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge mon_clk) begin
    if (mon_reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 2'd1;
      grant_q     <= 2'd0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      drop_q      <= 1'b0;
      tmo_q       <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      drop_q      <= drop_d;
      tmo_q       <= tmo_d;
      gap_q       <= gap_d;
    end
  end

  // Retrieve ack is same-cycle so the requester is released with the
  // handshake; the timeout ack travels with the registered drop pulse.
  // grant_q still names the owner while drop_q is high.
  always_comb begin
    ack = 4'b0000;
    if (drop_q)
      ack[grant_q] = 1'b1;
    else if ((state_q == PRESENT) && out_retrieved && !mon_reset)
      ack[grant_q] = 1'b1;
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign drop      = drop_q;
  assign busy      = (state_q != IDLE);

`ifdef MON_TX_DROP_COUNT_EN
  logic [7:0] drop_cnt_q;

  // Counts with the drop pulse so the new value shows alongside it.
  always_ff @(posedge mon_clk) begin
    if (mon_reset)                         drop_cnt_q <= 8'h00;
    else if (drop_d && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'h01;
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_mon_tx_arbiter.sv
// Testbench for mon_tx_arbiter: directed scenarios followed by randomized
// packets, checked against a transaction-level model of grant order,
// launch timing, handshake and timeout.
module tb_mon_tx_arbiter;

  localparam int unsigned GAP  = 4;
  localparam int unsigned TMO  = 64;
  localparam int unsigned TWID = 7;

  logic        mon_clk = 1'b0;
  logic        mon_reset;
  logic [3:0]  req;
  logic [39:0] rd [4];
  logic [3:0]  ack;
  logic        sample_req_mode;
  logic        sample_req_tick;
  logic [39:0] out_data;
  logic        out_valid;
  logic        out_retrieved;
  logic        drop;
  logic        busy;
`ifdef MON_TX_DROP_COUNT_EN
  logic [7:0]  drop_count;
`endif

  always #5 mon_clk = ~mon_clk;

  mon_tx_arbiter #(
    .GAP_CYCLES (GAP),
    .TIMEOUT    (TMO),
    .TW         (TWID)
  ) dut (
    .mon_clk         (mon_clk),
    .mon_reset       (mon_reset),
    .req             (req),
    .req_data0       (rd[0]),
    .req_data1       (rd[1]),
    .req_data2       (rd[2]),
    .req_data3       (rd[3]),
    .ack             (ack),
    .sample_req_mode (sample_req_mode),
    .sample_req_tick (sample_req_tick),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_retrieved   (out_retrieved),
    .drop            (drop),
    .busy            (busy)
`ifdef MON_TX_DROP_COUNT_EN
    ,
    .drop_count      (drop_count)
`endif
  );

  int n_cmp    = 0;
  int n_bad    = 0;
  int cyc      = 0;
  int tick_pct = 0;
  int tick_at1 = -1;
  int tick_at2 = -1;
  bit mode_rand = 1'b0;
  int rr_m     = 1;
  int drops_m  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; drive this cycle's inputs 1 time unit after the edge.
  task automatic step();
    @(posedge mon_clk);
    cyc++;
    #1;
    out_retrieved   = 1'b0;
    sample_req_tick = (cyc == tick_at1) || (cyc == tick_at2) ||
                      (int'($urandom_range(99)) < tick_pct);
    if (mode_rand) sample_req_mode = ($urandom_range(3) != 0);
    #2;
  endtask

  // Reference winner: power-on first, else first pending of rr, rr+1, rr+2 (1..3 wrap).
  function automatic int pick(input logic [3:0] r, input int rr);
    if (r[0]) return 0;
    for (int k = 0; k < 3; k++) begin
      int c;
      c = (rr - 1 + k) % 3 + 1;
      if (r[c]) return c;
    end
    return 0;
  endfunction

  function automatic logic [3:0] onehot(input int i);
    return 4'(1) << i;
  endfunction

  // One packet. idle_cyc is the cycle the arbiter is expected to decide in.
  // want_idx < 0 lets the model choose the winner. chg replaces req right
  // after the grant. Returns the expected next decision cycle.
  task automatic do_pkt(input int idle_cyc, input int want_idx, input int delay,
                        input bit retr, input bit chg, input logic [3:0] new_req,
                        output int next_idle);
    int idx;
    logic [39:0] ed;
    int p;
    bit launched;
    int budget;
    idx = 0; ed = '0; launched = 1'b0; budget = 0; next_idle = 0;
    while (!launched && budget <= 600) begin
      if (cyc == idle_cyc) begin
        idx = (want_idx >= 0) ? want_idx : pick(req, rr_m);
        ed  = rd[idx];
      end
      if (chg && cyc == idle_cyc + 1) req = new_req;
      chk("valid_before_launch", 64'(out_valid), 64'(0));
      // Launch condition is evaluated in every slot-wait cycle after the decision.
      if (cyc > idle_cyc && (!sample_req_mode || sample_req_tick)) launched = 1'b1;
      step();
      budget++;
    end
    n_cmp++;
    assert (launched) else begin
      n_bad++;
      $error("FAIL launch_budget: observed no launch, expected launch within 600 cycles");
    end
    p = cyc;
    for (int k = 0; k <= int'(TMO); k++) begin
      if (retr && k == delay) begin
        out_retrieved = 1'b1;
        #1;
        chk("ack_on_retrieve", 64'(ack), 64'(onehot(idx)));
        chk("valid_on_retrieve", 64'(out_valid), 64'(1));
        chk("no_drop_on_retrieve", 64'(drop), 64'(0));
        chk("data_on_retrieve", 64'(out_data), 64'(ed));
        step();
        chk("valid_after_retrieve", 64'(out_valid), 64'(0));
        chk("ack_after_retrieve", 64'(ack), 64'(0));
        chk("busy_in_gap", 64'(busy), 64'(1));
        next_idle = p + delay + 1 + int'(GAP);
        break;
      end else if (k == int'(TMO)) begin
        chk("drop_on_timeout", 64'(drop), 64'(1));
        chk("ack_on_timeout", 64'(ack), 64'(onehot(idx)));
        chk("valid_on_timeout", 64'(out_valid), 64'(0));
        if (drops_m < 255) drops_m++;
`ifdef MON_TX_DROP_COUNT_EN
        chk("drop_count", 64'(drop_count), 64'(drops_m));
`endif
        step();
        chk("drop_one_cycle", 64'(drop), 64'(0));
        chk("ack_after_drop", 64'(ack), 64'(0));
        next_idle = p + int'(TMO) + int'(GAP);
        break;
      end else begin
        chk("valid_present", 64'(out_valid), 64'(1));
        chk("data_present", 64'(out_data), 64'(ed));
        chk("ack_idle", 64'(ack), 64'(0));
        chk("drop_idle", 64'(drop), 64'(0));
        step();
      end
    end
    if (idx != 0) rr_m = idx % 3 + 1;
  endtask

  initial begin
    int nxt;
    int t0;
    logic [3:0] r;
    int sel;
    int dly;
    bit rt;
    bit cg;

    mon_reset       = 1'b1;
    req             = 4'b0000;
    for (int i = 0; i < 4; i++) rd[i] = '0;
    sample_req_mode = 1'b0;
    sample_req_tick = 1'b0;
    out_retrieved   = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_ack", 64'(ack), 64'(0));
    chk("rst_drop", 64'(drop), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
`ifdef MON_TX_DROP_COUNT_EN
    chk("rst_drop_count", 64'(drop_count), 64'(0));
`endif
    mon_reset = 1'b0;

    // Single kbd packet: valid two cycles after req, retrieve three cycles later
    rd[1] = 40'h0A_1234_5678;
    req   = 4'b0010;
    t0    = cyc;
    do_pkt(t0, 1, 3, 1'b1, 1'b1, 4'b0000, nxt);
    while (cyc < nxt) begin
      chk("t1_busy_gap", 64'(busy), 64'(1));
      step();
    end
    chk("t1_idle_after_gap", 64'(busy), 64'(0));

    // Reset during PRESENT aborts: no ack even with a retrieve in that cycle
    rd[2] = 40'({$urandom(), $urandom()});
    req   = 4'b0100;
    step();
    step();
    chk("t5_valid", 64'(out_valid), 64'(1));
    step();
    mon_reset     = 1'b1;
    out_retrieved = 1'b1;
    #1;
    chk("t5_ack_in_reset", 64'(ack), 64'(0));
    step();
    chk("t5_valid_after", 64'(out_valid), 64'(0));
    chk("t5_ack_after", 64'(ack), 64'(0));
    chk("t5_busy_after", 64'(busy), 64'(0));
    chk("t5_drop_after", 64'(drop), 64'(0));
    mon_reset = 1'b0;
    req       = 4'b0000;
    rr_m      = 1;
    drops_m   = 0;
    step();

    // Round-robin 1,2,3,1,2,3; power-on raised during the last is served next
    for (int i = 0; i < 4; i++) rd[i] = 40'({$urandom(), $urandom()});
    req = 4'b1110;
    nxt = cyc;
    for (int i = 0; i < 6; i++)
      do_pkt(nxt, (i % 3) + 1, int'($urandom_range(5)), 1'b1, (i == 5), 4'b1111, nxt);
    do_pkt(nxt, 0, 1, 1'b1, 1'b1, 4'b1110, nxt);
    do_pkt(nxt, 1, 0, 1'b1, 1'b1, 4'b0000, nxt);

    // Mouse packet never retrieved: dropped after TMO cycles of out_valid
    rd[2] = 40'({$urandom(), $urandom()});
    req   = 4'b0100;
    do_pkt(nxt, 2, 0, 1'b0, 1'b1, 4'b0000, nxt);

    // Audio mode: launch only after the first tick; later tick in IDLE ignored
    sample_req_mode = 1'b1;
    rd[3]    = 40'({$urandom(), $urandom()});
    req      = 4'b1000;
    tick_at1 = nxt + 10;
    tick_at2 = nxt + 50;
    do_pkt(nxt, 3, 3, 1'b1, 1'b1, 4'b0000, nxt);
    while (cyc < tick_at2 + 5) begin
      chk("t3_no_spurious_valid", 64'(out_valid), 64'(0));
      if (cyc >= nxt) chk("t3_idle", 64'(busy), 64'(0));
      step();
    end
    tick_at1        = -1;
    tick_at2        = -1;
    sample_req_mode = 1'b0;
    nxt             = cyc;

    // Randomized packets against the model
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++) rd[i] = 40'({$urandom(), $urandom()});
      r = 4'($urandom_range(15));
      if (r == 4'b0000) r = 4'b0001 << $urandom_range(3);
      req = r;
      if ($urandom_range(3) == 0) begin
        mode_rand = 1'b1;
        tick_pct  = 25;
      end else begin
        mode_rand       = 1'b0;
        sample_req_mode = 1'b0;
        tick_pct        = 10;
      end
      sel = int'($urandom_range(9));
      rt  = (sel != 0);
      dly = (sel == 1) ? int'(TMO) - 1 : int'($urandom_range(6));
      cg  = ($urandom_range(3) == 0);
      do_pkt(nxt, -1, dly, rt, cg, 4'($urandom_range(15)), nxt);
    end
    mode_rand       = 1'b0;
    sample_req_mode = 1'b0;
    tick_pct        = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion, expected $finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
